cpu_control_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 55 +++++
 rtl/cpu_control_unit_pc.sv | 20 ++
 rtl/cpu_control_unit.sv | 111 +++++++++++
 tb/tb_cpu_control_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit multi-cycle CPU controller.
// Opcodes, controller states, ALU selects and instruction field positions.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'h0,
    OP_STORE = 4'h1,
    OP_LOAD  = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_HALT  = 4'h5
  } opcode_t;

  typedef enum logic [3:0] {
    INIT    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    LOAD_A  = 4'd3,
    LOAD_B  = 4'd4,
    STORE_S = 4'd5,
    ADD_S   = 4'd6,
    SUB_S   = 4'd7,
    HALT    = 4'd8
  } state_t;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int RA_HI = 11;
  localparam int RA_LO = 8;
  localparam int RB_HI = 7;
  localparam int RB_LO = 4;
  localparam int RD_HI = 3;
  localparam int RD_LO = 0;
  localparam int LA_HI = 11;
  localparam int LA_LO = 4;
  localparam int SA_HI = 7;
  localparam int SA_LO = 0;

  function automatic logic [3:0] f_ra(input logic [15:0] ir);
    return ir[RA_HI:RA_LO];
  endfunction

  function automatic logic [3:0] f_rb(input logic [15:0] ir);
    return ir[RB_HI:RB_LO];
  endfunction

  function automatic logic [3:0] f_rd(input logic [15:0] ir);
    return ir[RD_HI:RD_LO];
  endfunction

endpackage

// File: rtl/cpu_control_unit_pc.sv
// Program counter for the CPU controller.
// Synchronous active-low clear, wraps modulo 2^PC_W when incremented.
module program_counter #(
  parameter int PC_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute controller for the 16-bit CPU.
// Drives imem fetch, data memory strobes, regfile ports and the ALU select.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int PC_W     = 7,
  parameter int D_ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         instr_in,
  output logic                imem_rd,
  output logic [PC_W-1:0]     pc_addr,
  output logic [D_ADDR_W-1:0] d_addr,
  output logic                d_rd,
  output logic                d_wr,
  output logic                rf_s,
  output logic [3:0]          rf_w_addr,
  output logic                rf_w_wr,
  output logic [3:0]          rf_ra_addr,
  output logic [3:0]          rf_rb_addr,
  output logic [2:0]          alu_sel,
  output logic                halted
);

  state_t      state;
  logic [15:0] ir;
  logic [3:0]  op_in;

  assign op_in = instr_in[OP_HI:OP_LO];

  program_counter #(.PC_W(PC_W)) u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (state == DECODE),
    .pc    (pc_addr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= INIT;
      ir    <= '0;
    end else begin
      case (state)
        INIT:    state <= FETCH;
        FETCH:   state <= DECODE;
        DECODE: begin
          ir <= instr_in;
          case (op_in)
            OP_STORE: state <= STORE_S;
            OP_LOAD:  state <= LOAD_A;
            OP_ADD:   state <= ADD_S;
            OP_SUB:   state <= SUB_S;
            OP_HALT:  state <= HALT;
            default:  state <= FETCH;
          endcase
        end
        LOAD_A:  state <= LOAD_B;
        LOAD_B:  state <= FETCH;
        STORE_S: state <= FETCH;
        ADD_S:   state <= FETCH;
        SUB_S:   state <= FETCH;
        HALT:    state <= HALT;
        default: state <= INIT;
      endcase
    end
  end

  // Moore decode from the registered state and IR.
  always_comb begin
    imem_rd    = 1'b0;
    d_addr     = '0;
    d_rd       = 1'b0;
    d_wr       = 1'b0;
    rf_s       = 1'b0;
    rf_w_addr  = '0;
    rf_w_wr    = 1'b0;
    rf_ra_addr = '0;
    rf_rb_addr = '0;
    alu_sel    = ALU_PASS;
    halted     = 1'b0;
    case (state)
      FETCH: imem_rd = 1'b1;
      LOAD_A: begin
        d_addr = ir[LA_HI:LA_LO];
        d_rd   = 1'b1;
      end
      LOAD_B: begin
        d_addr    = ir[LA_HI:LA_LO];
        rf_s      = 1'b1;
        rf_w_addr = f_rd(ir);
        rf_w_wr   = 1'b1;
      end
      STORE_S: begin
        rf_ra_addr = f_ra(ir);
        d_addr     = ir[SA_HI:SA_LO];
        d_wr       = 1'b1;
      end
      ADD_S, SUB_S: begin
        rf_ra_addr = f_ra(ir);
        rf_rb_addr = f_rb(ir);
        rf_w_addr  = f_rd(ir);
        rf_w_wr    = 1'b1;
        alu_sel    = (state == ADD_S) ? ALU_ADD : ALU_SUB;
      end
      HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit.
// Cycle-by-cycle expected output table plus reset, halt and wrap sequences.
module tb_cpu_control_unit;

  typedef struct packed {
    logic       ir;
    logic       dr;
    logic       dw;
    logic       s;
    logic       ww;
    logic       h;
    logic [6:0] pc;
    logic [7:0] da;
    logic [3:0] wa;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] alu;
  } outs_t;

  typedef struct {
    string name;
    outs_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr_in = '0;
  logic        imem_rd;
  logic [6:0]  pc_addr;
  logic [7:0]  d_addr;
  logic        d_rd;
  logic        d_wr;
  logic        rf_s;
  logic [3:0]  rf_w_addr;
  logic        rf_w_wr;
  logic [3:0]  rf_ra_addr;
  logic [3:0]  rf_rb_addr;
  logic [2:0]  alu_sel;
  logic        halted;

  logic [15:0] imem [0:127];
  int n_cmp = 0;
  int n_bad = 0;

  cpu_control_unit #(.PC_W(7), .D_ADDR_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_in   (instr_in),
    .imem_rd    (imem_rd),
    .pc_addr    (pc_addr),
    .d_addr     (d_addr),
    .d_rd       (d_rd),
    .d_wr       (d_wr),
    .rf_s       (rf_s),
    .rf_w_addr  (rf_w_addr),
    .rf_w_wr    (rf_w_wr),
    .rf_ra_addr (rf_ra_addr),
    .rf_rb_addr (rf_rb_addr),
    .alu_sel    (alu_sel),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (imem_rd) instr_in <= imem[pc_addr];

  function automatic outs_t mk(
    input logic ir, input logic dr, input logic dw,
    input logic s, input logic ww, input logic h,
    input int pc, input int da, input int wa,
    input int ra, input int rb, input int alu);
    outs_t o;
    o = '{ir, dr, dw, s, ww, h, 7'(pc), 8'(da),
          4'(wa), 4'(ra), 4'(rb), 3'(alu)};
    return o;
  endfunction

  function automatic outs_t cur();
    outs_t o;
    o = '{imem_rd, d_rd, d_wr, rf_s, rf_w_wr, halted, pc_addr,
          d_addr, rf_w_addr, rf_ra_addr, rf_rb_addr, alu_sel};
    return o;
  endfunction

  task automatic chk(input string name, input outs_t exp);
    outs_t got;
    got = cur();
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic reset2();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t tbl [18];
  outs_t idle0;
  bit seen127;
  bit wrapped;
  bit hit;

  initial begin
    for (int i = 0; i < 128; i++) imem[i] = 16'h0000;
    imem[0] = 16'h2AB3;
    imem[1] = 16'h3125;
    imem[2] = 16'h4125;
    imem[3] = 16'h1742;
    imem[4] = 16'hF000;
    imem[5] = 16'h5000;

    tbl[0]  = '{"ld_fetch",  mk(1,0,0,0,0,0, 0,0,0,0,0,0)};
    tbl[1]  = '{"ld_decode", mk(0,0,0,0,0,0, 0,0,0,0,0,0)};
    tbl[2]  = '{"load_a",    mk(0,1,0,0,0,0, 1,'hAB,0,0,0,0)};
    tbl[3]  = '{"load_b",    mk(0,0,0,1,1,0, 1,'hAB,3,0,0,0)};
    tbl[4]  = '{"add_fetch", mk(1,0,0,0,0,0, 1,0,0,0,0,0)};
    tbl[5]  = '{"add_dec",   mk(0,0,0,0,0,0, 1,0,0,0,0,0)};
    tbl[6]  = '{"add_s",     mk(0,0,0,0,1,0, 2,0,5,1,2,1)};
    tbl[7]  = '{"sub_fetch", mk(1,0,0,0,0,0, 2,0,0,0,0,0)};
    tbl[8]  = '{"sub_dec",   mk(0,0,0,0,0,0, 2,0,0,0,0,0)};
    tbl[9]  = '{"sub_s",     mk(0,0,0,0,1,0, 3,0,5,1,2,2)};
    tbl[10] = '{"st_fetch",  mk(1,0,0,0,0,0, 3,0,0,0,0,0)};
    tbl[11] = '{"st_dec",    mk(0,0,0,0,0,0, 3,0,0,0,0,0)};
    tbl[12] = '{"store_s",   mk(0,0,1,0,0,0, 4,'h42,0,7,0,0)};
    tbl[13] = '{"und_fetch", mk(1,0,0,0,0,0, 4,0,0,0,0,0)};
    tbl[14] = '{"und_dec",   mk(0,0,0,0,0,0, 4,0,0,0,0,0)};
    tbl[15] = '{"hlt_fetch", mk(1,0,0,0,0,0, 5,0,0,0,0,0)};
    tbl[16] = '{"hlt_dec",   mk(0,0,0,0,0,0, 5,0,0,0,0,0)};
    tbl[17] = '{"halt",      mk(0,0,0,0,0,1, 6,0,0,0,0,0)};
    idle0 = mk(0,0,0,0,0,0, 0,0,0,0,0,0);

    // Power-on reset, then the main program.
    reset2();
    chk("reset_init", idle0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_fetch", tbl[0].exp);
    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      chk(tbl[i].name, tbl[i].exp);
      @(negedge clk);
    end
    for (int i = 0; i < 20; i++) begin
      chk("halt_hold", tbl[17].exp);
      @(negedge clk);
    end

    // Reset out of HALT.
    reset2();
    chk("reset_from_halt", idle0);

    // Reset during LOAD_A aborts the load.
    rst_n = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      if (d_rd) hit = 1'b1;
    end
    chk_bit("reach_load_a", hit, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midload_reset", idle0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midload_refetch", mk(1,0,0,0,0,0, 0,0,0,0,0,0));
    @(negedge clk);
    chk("midload_redecode", idle0);

    // PC wrap: NOOPs everywhere, HALT placed at 1 once PC hits 127.
    reset2();
    for (int i = 0; i < 128; i++) imem[i] = 16'h0000;
    rst_n = 1'b1;
    seen127 = 1'b0;
    wrapped = 1'b0;
    for (int i = 0; i < 600 && !halted; i++) begin
      @(negedge clk);
      if (seen127 && !wrapped && pc_addr != 7'd127) begin
        wrapped = 1'b1;
        chk_bit("wrap_to_zero", pc_addr == 7'd0, 1'b1);
      end
      if (pc_addr == 7'd127 && !seen127) begin
        seen127 = 1'b1;
        imem[1] = 16'h5000;
      end
    end
    chk_bit("wrap_seen", wrapped, 1'b1);
    chk_bit("wrap_halted", halted, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("wrap_halt_hold", mk(0,0,0,0,0,1, 2,0,0,0,0,0));
    end
    reset2();
    chk("wrap_reset", idle0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
